// File: rtl/magma_round_ctrl.sv
// Magma (GOST 28147-89) round sequencer: load, 32 keyed rounds, done.
// Define MAGMA_CTRL_STEP_EN to add a single-step input for board debug.
module magma_round_ctrl #(
  parameter int ROUND_CYCLES = 1,
  parameter int ROUNDS       = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         decrypt,
  input  logic         cancel,
`ifdef MAGMA_CTRL_STEP_EN
  input  logic         step,
`endif
  input  logic [255:0] key_in,
  output logic         ld_en,
  output logic         rnd_en,
  output logic         rnd_last,
  output logic [31:0]  rnd_key,
  output logic [4:0]   round_idx,
  output logic [2:0]   key_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_ROUND, S_DONE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(ROUND_CYCLES - 1);
  localparam logic [4:0] RND_LAST = 5'(ROUNDS - 1);

  state_t       r_state;
  state_t       w_next;
  logic [255:0] r_key;
  logic         r_dir;
  logic [3:0]   r_cnt;
  logic [4:0]   r_rnd;
  logic         w_act;
  logic         w_adv;
  logic         w_rev;
  logic [2:0]   w_kidx;
  logic [31:0]  w_key;

`ifdef MAGMA_CTRL_STEP_EN
  assign w_adv = (r_cnt == CNT_LAST) && step;
`else
  assign w_adv = (r_cnt == CNT_LAST);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_rnd   <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key <= key_in;
            r_dir <= decrypt;
            r_cnt <= '0;
            r_rnd <= '0;
          end
        end
        S_ROUND: begin
          if (!cancel) begin
            if (w_adv) begin
              r_cnt <= '0;
              r_rnd <= r_rnd + 5'd1;
            end else if (r_cnt != CNT_LAST) begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next   = r_state;
    ld_en    = 1'b0;
    rnd_en   = 1'b0;
    rnd_last = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        busy = 1'b1;
        if (cancel) begin
          w_next = S_IDLE;
        end else begin
          ld_en  = 1'b1;
          w_next = S_ROUND;
        end
      end
      S_ROUND: begin
        busy = 1'b1;
        if (cancel) begin
          w_next = S_IDLE;
        end else if (w_adv) begin
          rnd_en = 1'b1;
          if (r_rnd == RND_LAST) begin
            rnd_last = 1'b1;
            w_next   = S_DONE;
          end
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Schedule runs K0..K7 forward, then reverses: after round 8 when
  // decrypting, after round 24 when encrypting.
  assign w_act  = (r_state == S_LOAD) || (r_state == S_ROUND);
  assign w_rev  = r_dir ? (r_rnd >= 5'd8) : (r_rnd >= 5'd24);
  assign w_kidx = w_rev ? ~r_rnd[2:0] : r_rnd[2:0];

  always_comb begin
    w_key = '0;
    for (int i = 0; i < 8; i++) begin
      if (w_kidx == 3'(i)) w_key = r_key[255 - 32*i -: 32];
    end
  end

  assign rnd_key   = w_act ? w_key  : '0;
  assign key_idx   = w_act ? w_kidx : '0;
  assign round_idx = w_act ? r_rnd  : '0;

endmodule

// File: doc/magma_round_ctrl.md
Name: magma_round_ctrl

Overview:
- Sequencer for the Magma (GOST 28147-89) 64-bit block cipher round unit.
- Accepts a start request from the data/key entry front end and latches the 256-bit key.
- Drives load/round-enable strobes and the per-round 32-bit subkey to the external round datapath, with the direction-dependent key schedule.
- Signals completion to the display/result stage.

Parameters:
- ROUND_CYCLES, 1, clock cycles per round (1..15); subkey held for the whole round.
- ROUNDS, 32, round count; fixed at 32, any other value is unsupported.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; accepted only in IDLE
- decrypt  in  1  direction, sampled with an accepted start (0 = encrypt)
- cancel  in  1  abort the current operation
- key_in  in  256  cipher key, sampled with an accepted start; K0 = key_in[255:224] ... K7 = key_in[31:0]
- ld_en  out  1  load plaintext/ciphertext into the round-unit state register
- rnd_en  out  1  commit one round in the round unit
- rnd_last  out  1  high with rnd_en on round 31 (final round, no half swap)
- rnd_key  out  32  current subkey
- round_idx  out  5  current round 0..31
- key_idx  out  3  current subkey index
- busy  out  1  operation in progress
- done  out  1  single-cycle completion pulse

Behaviour:
- Reset: state IDLE; all outputs 0; latched key and decrypt flag cleared.
- States: IDLE, LOAD, ROUND, DONE.
- IDLE -> LOAD: on start.
  - Latch key_in into key_q and decrypt into dir_q.
  - key_in/decrypt changes after acceptance have no effect.
- LOAD: exactly one cycle.
  - ld_en=1, busy=1.
  - round_idx=0, cycle counter=0.
  - Next state ROUND.
- ROUND: busy=1; rnd_key = key_q[255-32*key_idx -: 32], valid every ROUND cycle.
  - Cycle counter counts 0..ROUND_CYCLES-1.
  - rnd_en=1 only on counter = ROUND_CYCLES-1.
  - On that cycle, round_idx increments and the counter wraps to 0.
  - On the rnd_en cycle with round_idx=31: rnd_last=1, next state DONE.
- Encrypt key schedule:
  - key_idx = round_idx[2:0] for rounds 0..23.
  - key_idx = 7 - round_idx[2:0] for rounds 24..31.
  - Resulting order: K0..K7 x3, then K7..K0.
- Decrypt key schedule:
  - key_idx = round_idx[2:0] for rounds 0..7.
  - key_idx = 7 - round_idx[2:0] for rounds 8..31.
  - Resulting order: K0..K7, then K7..K0 x3.
- DONE: one cycle, done=1, busy=0; then IDLE.
- Latency:
  - start accepted at cycle 0 -> ld_en at cycle 1.
  - First rnd_en at cycle 1+ROUND_CYCLES.
  - done at cycle 2+32*ROUND_CYCLES.
  - With ROUND_CYCLES=1, done is at cycle 34.
- start outside IDLE: ignored, no queuing; this includes start coincident with the DONE cycle.
- cancel in LOAD or ROUND:
  - Next cycle IDLE, busy=0, no done pulse.
  - rnd_en/ld_en forced 0 in the cancel cycle.
- cancel in IDLE or DONE: no effect (DONE still pulses).
- start and cancel together in IDLE: start wins.
- reset overrides everything, including mid-operation; no done pulse is produced.
- rnd_key, key_idx and round_idx read 0 outside LOAD/ROUND.

Optional Feature:
- Macro: MAGMA_CTRL_STEP_EN (single-step mode for board debug via the push buttons).
- With the macro defined:
  - Extra input port step (1 bit, already edge-detected single-cycle pulse).
  - In ROUND, the cycle counter holds at ROUND_CYCLES-1 and rnd_en is withheld until step=1.
  - Each step pulse commits exactly one round.
  - step outside ROUND is ignored.
  - cancel and reset behave as in normal mode.
- Without the macro: no step port; free-running operation as above.

Test Plan:
- Encrypt, ROUND_CYCLES=1, key_in = 256'h0123...(K0=32'h00000000..K7=32'h77777777 pattern) -> ld_en at cycle 1, rnd_en cycles 2..33, key_idx sequence 0..7,0..7,0..7,7..0, rnd_last at cycle 33 only, done at cycle 34.
- Decrypt, same key -> key_idx sequence 0..7,7..0,7..0,7..0; rnd_key at round 8 = K7; done at cycle 34.
- ROUND_CYCLES=3 -> rnd_en every 3rd cycle, 32 pulses total, rnd_key stable across each 3-cycle round, done at cycle 98.
- Behaviour during an operation:
  - start re-pulsed at round 5 -> ignored.
  - key_in changed at round 5 -> rnd_key sequence unchanged.
  - start pulsed in the DONE cycle -> ignored, controller returns to IDLE.
- cancel at round 10 -> next cycle busy=0, no further rnd_en, no done; a new start then runs a full 32-round sequence.
- reset asserted at round 20 -> all outputs 0 next cycle, no done; with MAGMA_CTRL_STEP_EN, 32 step pulses are required to reach done.
